// File: rtl/ascon_io_sequencer.sv
// ascon_io_sequencer: byte-serial load/unload sequencer around a masked Ascon
// core. Operands are latched on start, streamed MSB-first one byte per cycle
// with fresh share randomness, the core is kicked and awaited, and the serial
// ciphertext/tag bytes are collected back into parallel registers.
// Optional WAIT watchdog: define ASCON_SEQ_TIMEOUT_EN.
module ascon_io_sequencer #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startxSI,
  input  logic [K-1:0] keyxSI,
  input  logic [127:0] noncexSI,
  input  logic [L-1:0] adxSI,
  input  logic [Y-1:0] ptxSI,
  input  logic [135:0] rndxSI,
  output logic         busyxSO,
  output logic         donexSO,
  output logic         errorxSO,
  output logic [Y-1:0] ctxSO,
  output logic [127:0] tagxSO,
  output logic [23:0]  core_keyxSO,
  output logic [23:0]  core_noncexSO,
  output logic [23:0]  core_adxSO,
  output logic [23:0]  core_ptxSO,
  output logic [55:0]  core_r64xSO,
  output logic [7:0]   core_r128xSO,
  output logic [7:0]   core_rptxSO,
  output logic         core_startxSO,
  input  logic [7:0]   core_ctxSI,
  input  logic [7:0]   core_tagxSI,
  input  logic         core_readyxSI
);
  localparam int MAXW = ((K >= L) && (K >= Y)) ? K : ((L >= Y) ? L : Y);
  localparam int NB   = MAXW / 8;
  localparam int CW   = (NB > 2) ? $clog2(NB) : 1;
  // nonce/tag bytes beyond the transfer length are never reached by the counter
  localparam int TB   = (NB < 16) ? NB : 16;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_PAIR = CW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SETTLE = 3'd4,
    UNLOAD = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t          state_r, nextState_s;
  logic [CW-1:0]   cnt_r;
  logic [K-1:0]    key_r;
  logic [127:0]    nonce_r;
  logic [L-1:0]    ad_r;
  logic [Y-1:0]    pt_r;
  logic [Y-1:0]    ct_r;
  logic [127:0]    tag_r;
  logic            busy_r, done_r, coreStart_r;
  logic            accept_s, timeout_s;
  logic [7:0]      keyByte_s, nonceByte_s, adByte_s, ptByte_s;

  assign accept_s = (state_r == IDLE) && startxSI;

  // Next-state decode; phase lengths are timed by the shared byte counter
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    if (startxSI) nextState_s = LOAD; else nextState_s = IDLE;
      LOAD:    if (cnt_r == LAST_BYTE) nextState_s = START; else nextState_s = LOAD;
      START:   if (cnt_r == LAST_PAIR) nextState_s = WAIT; else nextState_s = START;
      WAIT: begin
        if (core_readyxSI)  nextState_s = SETTLE;
        else if (timeout_s) nextState_s = DONE;
        else                nextState_s = WAIT;
      end
      SETTLE:  if (cnt_r == LAST_PAIR) nextState_s = UNLOAD; else nextState_s = SETTLE;
      UNLOAD:  if (cnt_r == LAST_BYTE) nextState_s = DONE; else nextState_s = UNLOAD;
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State, counter, operand latches, result collection and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      key_r       <= '0;
      nonce_r     <= 128'h0;
      ad_r        <= '0;
      pt_r        <= '0;
      ct_r        <= '0;
      tag_r       <= 128'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      coreStart_r <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      // counter restarts at every phase change
      if (nextState_s != state_r) cnt_r <= '0;
      else                        cnt_r <= cnt_r + CNT_ONE;
      busy_r      <= (nextState_s != IDLE) && (nextState_s != DONE);
      done_r      <= (nextState_s == DONE);
      coreStart_r <= (nextState_s == START);
      if (accept_s) begin
        key_r   <= keyxSI;
        nonce_r <= noncexSI;
        ad_r    <= adxSI;
        pt_r    <= ptxSI;
        ct_r    <= '0;
        tag_r   <= 128'h0;
      end else if (state_r == UNLOAD) begin
        // bytes past the ct/tag width are simply not stored
        for (int b = 0; b < Y/8; b++)
          if (cnt_r == CW'(b)) ct_r[8*b +: 8] <= core_ctxSI;
        for (int b = 0; b < TB; b++)
          if (cnt_r == CW'(b)) tag_r[8*b +: 8] <= core_tagxSI;
      end
    end
  end

  // Select byte cnt_r of each operand, MSB first; past the operand width it reads 0
  always_comb begin
    keyByte_s   = 8'h00;
    nonceByte_s = 8'h00;
    adByte_s    = 8'h00;
    ptByte_s    = 8'h00;
    for (int b = 0; b < K/8; b++)
      keyByte_s = (cnt_r == CW'(b)) ? key_r[K-1-8*b -: 8] : keyByte_s;
    for (int b = 0; b < TB; b++)
      nonceByte_s = (cnt_r == CW'(b)) ? nonce_r[127-8*b -: 8] : nonceByte_s;
    for (int b = 0; b < L/8; b++)
      adByte_s = (cnt_r == CW'(b)) ? ad_r[L-1-8*b -: 8] : adByte_s;
    for (int b = 0; b < Y/8; b++)
      ptByte_s = (cnt_r == CW'(b)) ? pt_r[Y-1-8*b -: 8] : ptByte_s;
  end

  // Core share bus: data byte plus randomness slices during LOAD, quiet otherwise
  always_comb begin
    core_keyxSO   = 24'h000000;
    core_noncexSO = 24'h000000;
    core_adxSO    = 24'h000000;
    core_ptxSO    = 24'h000000;
    core_r64xSO   = 56'h0;
    core_r128xSO  = 8'h00;
    core_rptxSO   = 8'h00;
    if (state_r == LOAD) begin
      core_r128xSO  = rndxSI[135:128];
      core_rptxSO   = rndxSI[127:120];
      core_r64xSO   = rndxSI[119:64];
      core_keyxSO   = {rndxSI[63:48], keyByte_s};
      core_adxSO    = {rndxSI[47:32], adByte_s};
      core_ptxSO    = {rndxSI[31:16], ptByte_s};
      core_noncexSO = {rndxSI[15:0],  nonceByte_s};
    end else begin
      core_r128xSO  = 8'h00;
    end
  end

`ifdef ASCON_SEQ_TIMEOUT_EN
  logic [15:0] wdog_r;
  logic        error_r;

  // 65535th ready-less WAIT cycle is the timeout
  assign timeout_s = (state_r == WAIT) && !core_readyxSI && (wdog_r == 16'hFFFE);

  // Watchdog counts consecutive WAIT cycles; error is sticky until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_r  <= 16'h0000;
      error_r <= 1'b0;
    end else begin
      if ((state_r == WAIT) && (nextState_s == WAIT)) wdog_r <= wdog_r + 16'h0001;
      else                                            wdog_r <= 16'h0000;
      if (accept_s)       error_r <= 1'b0;
      else if (timeout_s) error_r <= 1'b1;
      else                error_r <= error_r;
    end
  end

  assign errorxSO = error_r;
`else
  assign timeout_s = 1'b0;
  assign errorxSO  = 1'b0;
`endif

  assign busyxSO       = busy_r;
  assign donexSO       = done_r;
  assign core_startxSO = coreStart_r;
  assign ctxSO         = ct_r;
  assign tagxSO        = tag_r;

endmodule

// File: doc/ascon_io_sequencer.md
ASCON_IO_SEQUENCER -- requirements
Module: ascon_io_sequencer

Interface
REQ-001 SHALL have parameter K, default 128, key width in bits (multiple of 8).
REQ-002 SHALL have parameter L, default 40, associated-data width in bits (multiple of 8).
REQ-003 SHALL have parameter Y, default 40, plaintext/ciphertext width in bits (multiple of 8).
REQ-004 SHALL derive NB = max(K,L,Y)/8 transfer bytes; the nonce is fixed at 128 bits.
REQ-005 SHALL have ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
startxSI  in  1  host request to encrypt
keyxSI  in  K  key
noncexSI  in  128  nonce
adxSI  in  L  associated data
ptxSI  in  Y  plaintext
rndxSI  in  136  fresh masking randomness, one word per load cycle
busyxSO  out  1  high from accepted start until done
donexSO  out  1  one-cycle completion pulse
errorxSO  out  1  watchdog timeout flag (REQ-030)
ctxSO  out  Y  collected ciphertext
tagxSO  out  128  collected tag
core_keyxSO, core_noncexSO, core_adxSO, core_ptxSO  out  24 each  share-bytes to core
core_r64xSO  out  56, core_r128xSO  out  8, core_rptxSO  out  8  core masks
core_startxSO  out  1  encryption_start to core
core_ctxSI  in  8, core_tagxSI  in  8  core serial outputs
core_readyxSI  in  1  encryption_ready from core

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, START, WAIT, SETTLE, UNLOAD, DONE.
REQ-007 IDLE: on startxSI=1 SHALL latch key/nonce/ad/pt, clear ctxSO/tagxSO/errorxSO, raise busyxSO next cycle, and go to LOAD.
REQ-008 startxSI while busyxSO=1 SHALL be ignored.
REQ-009 LOAD: SHALL last exactly NB cycles, with byte counter i = 0..NB-1.
REQ-010 In LOAD byte i, the low byte of each data port SHALL be source bits [W-1-8i : W-8-8i], MSB first.
REQ-011 Data bytes with 8i >= W SHALL be driven 0x00; the nonce uses W=128.
REQ-012 In LOAD, {core_r128xSO, core_rptxSO, core_r64xSO, core_keyxSO[23:8], core_adxSO[23:8], core_ptxSO[23:8], core_noncexSO[23:8]} SHALL equal rndxSI, concatenated in that order.
REQ-013 Outside LOAD all core_* data and mask outputs SHALL be zero.
REQ-014 START: core_startxSO SHALL be 1 for exactly 2 cycles, then the FSM enters WAIT.
REQ-015 WAIT: core_readyxSI SHALL be sampled only in WAIT; when 1, the FSM enters SETTLE next cycle, even if ready was already high on entry.
REQ-016 SETTLE: SHALL last exactly 2 cycles, then the FSM enters UNLOAD.
REQ-017 UNLOAD: SHALL last NB cycles; at byte j, ctxSO[8j+7:8j] <= core_ctxSI and tagxSO[8j+7:8j] <= core_tagxSI.
REQ-018 UNLOAD writes with 8j beyond Y (ct) or 128 (tag) SHALL be discarded.
REQ-019 DONE: donexSO=1 for one cycle; busyxSO falls in the same cycle and ctxSO/tagxSO hold until the next accepted start.
REQ-020 Latency from the start-accept edge to the donexSO cycle SHALL be NB+2+w+2+NB+1 cycles, where w>=1 is the number of WAIT cycles.
REQ-021 A new start SHALL be accepted in the cycle after DONE.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD and mid-UNLOAD.
REQ-023 Under reset, all outputs SHALL be 0: busy, done, error, ctxSO, tagxSO, all core_*.
REQ-024 Under reset, the byte counter and watchdog SHALL be cleared.
REQ-025 startxSI asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-026 Macro ASCON_SEQ_TIMEOUT_EN SHALL select watchdog support.
REQ-027 With ASCON_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL count WAIT cycles.
REQ-028 With ASCON_SEQ_TIMEOUT_EN defined, reaching 65535 without ready SHALL set errorxSO=1 (sticky until the next accepted start or reset) and go to DONE, skipping SETTLE/UNLOAD.
REQ-029 In the timeout case, ctxSO and tagxSO SHALL remain zero.
REQ-030 Without ASCON_SEQ_TIMEOUT_EN, WAIT SHALL be unbounded and errorxSO SHALL be tied to 0.

Verification
REQ-031 Defaults, KEY=2db083053e848cefa30007336c47a5a1, NONCE=3f3607dbce3503ba84f5843d623de056, AD=PT=4153434f4e/6173636f6e -> LOAD byte0 low bytes key=2d, nonce=3f, ad=41, pt=61; byte4 ad=4e, pt=6e; bytes 5..15 ad=pt=00; byte15 key=a1, nonce=56.
REQ-032 Stub core raising ready 10 cycles after core_startxSO falls, streaming ct bytes 01..10 and tag bytes 11..20 -> core_startxSO high exactly 2 cycles; ctxSO=0504030201; tagxSO=201f...1211; donexSO 16+2+10+2+16+1=47 cycles after accept.
REQ-033 startxSI pulsed during LOAD and during WAIT -> ignored; exactly one donexSO pulse.
REQ-034 rst asserted at LOAD byte 7, then a fresh start -> all outputs 0 for the reset cycle; second run produces the full 16-byte stream from byte0.
REQ-035 Ready tied high before start -> WAIT lasts 1 cycle; total latency 38 cycles.
REQ-036 With ASCON_SEQ_TIMEOUT_EN, ready never asserted -> errorxSO=1 and donexSO after 65535 WAIT cycles; ctxSO=tagxSO=0; without the macro, busyxSO stays 1.
